// File: rtl/riscv_core_sequencer.sv
// Run-control sequencer for the single-cycle RISC-V core.
// The host flips cmd_toggle to issue a command; this block gates the core
// (core_en), owns its reset, drives the imem write port and reports status.
module riscv_core_sequencer #(
  parameter int IMEM_AW     = 8,
  parameter int XLEN        = 32,
  parameter int STEP_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYC     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_toggle,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [XLEN-1:0]    cmd_data,
  input  logic [XLEN-1:0]    core_pc,
  input  logic               imem_ready,
  output logic               core_rst_n,
  output logic               core_en,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               busy,
  output logic               done_toggle,
  output logic               err,
  output logic [2:0]         state_o,
  output logic [STEP_W-1:0]  steps_left,
  output logic [XLEN-1:0]    pc_snapshot
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_RST = 3'd2, S_RUN = 3'd3, S_STEP = 3'd4
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_HALT  = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_WRITE = 3'd4;
  localparam logic [2:0] OP_RESET = 3'd5;

  // Counter runs RST_CYC-1 .. 0 while the core is held in reset.
  localparam int              RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYC - 1);

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                tog_prev_q, tog_prev_d;
  logic                cmd_pulse;
  logic                core_rst_n_q, core_rst_n_d;
  logic [IMEM_AW-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [XLEN-1:0]     pc_snap_q, pc_snap_d;
  logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                retire;
  logic [STEP_W-1:0]   step_n;

  // Toggle synchronizer; an edge on the synced level is one command.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], cmd_toggle};
    tog_prev_d = sync_q[SYNC_STAGES-1];
    cmd_pulse  = sync_q[SYNC_STAGES-1] ^ tog_prev_q;
  end

  assign step_n = cmd_data[STEP_W-1:0];

  // State register and all sequencer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      tog_prev_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      steps_q      <= '0;
      pc_snap_q    <= '0;
      rst_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tog_prev_q   <= tog_prev_d;
      core_rst_n_q <= core_rst_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      steps_q      <= steps_d;
      pc_snap_q    <= pc_snap_d;
      rst_cnt_q    <= rst_cnt_d;
    end
  end

  // Next-state: command decode per state, retire bookkeeping, PC capture.
  always_comb begin
    state_d      = state_q;
    core_rst_n_d = core_rst_n_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    steps_d      = steps_q;
    rst_cnt_d    = rst_cnt_q;
    retire       = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_pulse) begin
        case (cmd_op)
          OP_NOP:  begin err_d = 1'b0; retire = 1'b1; end
          OP_HALT: retire = 1'b1;
          OP_RUN: begin
            if (!core_rst_n_q) err_d = 1'b1;
            else begin state_d = S_RUN; retire = 1'b1; end
          end
          OP_STEP: begin
            if (!core_rst_n_q)      err_d = 1'b1;
            else if (step_n == '0)  retire = 1'b1;
            else begin steps_d = step_n; state_d = S_STEP; end
          end
          OP_WRITE: begin
            addr_d  = cmd_addr;
            wdata_d = cmd_data;
            state_d = S_LOAD;
          end
          OP_RESET: begin
            core_rst_n_d = 1'b0;
            rst_cnt_d    = RC_LOAD;
            state_d      = S_RST;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_LOAD: begin
        if (cmd_pulse) err_d = 1'b1;
        if (imem_ready) begin state_d = S_IDLE; retire = 1'b1; end
      end
      S_RST: begin
        if (cmd_pulse) err_d = 1'b1;
        if (rst_cnt_q == '0) begin
          core_rst_n_d = 1'b1;
          state_d      = S_IDLE;
          retire       = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end
      S_RUN: if (cmd_pulse) begin
        if (cmd_op == OP_HALT) begin state_d = S_IDLE; retire = 1'b1; end
        else err_d = 1'b1;
      end
      S_STEP: begin
        if (cmd_pulse && cmd_op == OP_HALT) begin
          steps_d = '0;
          state_d = S_IDLE;
          retire  = 1'b1;
        end else begin
          if (cmd_pulse) err_d = 1'b1;
          if (steps_q == '0) begin state_d = S_IDLE; retire = 1'b1; end
          else steps_d = steps_q - STEP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    done_d    = retire ? ~done_q : done_q;
    pc_snap_d = (state_d == S_IDLE && state_q != S_IDLE) ? core_pc : pc_snap_q;
  end

  // Outputs decoded from state; core_en drops as soon as the step budget is spent.
  always_comb begin
    core_en     = (state_q == S_RUN) || (state_q == S_STEP && steps_q != '0);
    imem_we     = (state_q == S_LOAD);
    busy        = (state_q != S_IDLE) && (state_q != S_RUN);
    state_o     = state_q;
    core_rst_n  = core_rst_n_q;
    imem_addr   = addr_q;
    imem_wdata  = wdata_q;
    done_toggle = done_q;
    err         = err_q;
    steps_left  = steps_q;
    pc_snapshot = pc_snap_q;
  end

endmodule
